// File: rtl/fp_arith_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder
// used by the FP mantissa and exponent datapaths.
package fp_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nchunk(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

   // A single-chunk configuration still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The sub port exists only when SEQ_ADDER_SUB_EN is defined.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 25
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             cin;
`ifdef SEQ_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;

`ifdef SEQ_ADDER_SUB_EN
   modport master (
      output in_valid, in1, in2, cin, sub, out_ready,
      input  in_ready, out_valid, S, Cout
   );
   modport slave (
      input  in_valid, in1, in2, cin, sub, out_ready,
      output in_ready, out_valid, S, Cout
   );
`else
   modport master (
      output in_valid, in1, in2, cin, out_ready,
      input  in_ready, out_valid, S, Cout
   );
   modport slave (
      input  in_valid, in1, in2, cin, out_ready,
      output in_ready, out_valid, S, Cout
   );
`endif

endinterface

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder built from full-adder cells.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o
);

   logic [CHUNK:0] c_s;

   // Full-adder ripple from bit 0 upward.
   always_comb begin
      c_s    = '0;
      sum_o  = '0;
      c_s[0] = cin_i;
      for (int i = 0; i < CHUNK; i++) begin
         sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
         c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = c_s[CHUNK];
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock.
// Define SEQ_ADDER_SUB_EN to add the sub port (in1 + ~in2 + 1).
module seq_chunk_adder
   import fp_arith_pkg::*;
#(
   parameter int WIDTH = 25,
   parameter int CHUNK = 8
) (
   input logic             clk,
   input logic             rst,
   seq_chunk_adder_if.slave bus
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int PW     = NCHUNK * CHUNK;
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   state_e          state_q, state_d;
   logic [PW-1:0]   a_q, a_d;
   logic [PW-1:0]   b_q, b_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic            cout_q, cout_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;

   int              base_s;
   logic [CHUNK-1:0] chunk_a_s;
   logic [CHUNK-1:0] chunk_b_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic            chunk_cout_s;

   assign base_s    = int'(cnt_q) * CHUNK;
   assign chunk_a_s = a_q[base_s +: CHUNK];
   assign chunk_b_s = b_q[base_s +: CHUNK];

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a_i    (chunk_a_s),
      .b_i    (chunk_b_s),
      .cin_i  (carry_q),
      .sum_o  (chunk_sum_s),
      .cout_o (chunk_cout_s)
   );

   // Next-state, operand capture and per-chunk result update.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      s_d      = s_q;
      cout_d   = cout_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d              = '0;
               b_d              = '0;
               a_d[WIDTH-1:0]   = bus.in1;
`ifdef SEQ_ADDER_SUB_EN
               if (bus.sub) begin
                  b_d[WIDTH-1:0] = ~bus.in2;
                  carry_d        = 1'b1;
               end else begin
                  b_d[WIDTH-1:0] = bus.in2;
                  carry_d        = bus.cin;
               end
`else
               b_d[WIDTH-1:0]   = bus.in2;
               carry_d          = bus.cin;
`endif
               cnt_d            = '0;
               state_d          = RUN;
            end else begin
               state_d          = IDLE;
            end
         end
         RUN: begin
            for (int i = 0; i < WIDTH; i++) begin
               if (i >= base_s && i < base_s + CHUNK) begin
                  s_d[i] = chunk_sum_s[i - base_s];
               end else begin
                  s_d[i] = s_q[i];
               end
            end
            carry_d = chunk_cout_s;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = DONE;
               // Carry out is bit WIDTH of the padded sum, not the raw chunk carry.
               if (WIDTH - base_s == CHUNK) begin
                  cout_d = chunk_cout_s;
               end else begin
                  cout_d = chunk_sum_s[WIDTH - base_s];
               end
            end else begin
               cnt_d   = cnt_q + CW'(1'b1);
               state_d = RUN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.S         = s_q;
   assign bus.Cout      = cout_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, and keeps the inter-chunk carry in a register.
- Successor to the fixed-width ripple adders. Serves the FP mantissa and exponent datapaths when area matters more than latency.
- Valid/ready handshake on both input and output. Processes one operation at a time.

Parameters:
- WIDTH, 25, operand and sum width in bits (>=1).
- CHUNK, 8, bits added per cycle (1 <= CHUNK <= WIDTH).
- NCHUNK, derived as ceil(WIDTH/CHUNK), number of compute cycles. Local constant, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract select (present only with SEQ_ADDER_SUB_EN)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- S  out  WIDTH  sum
- Cout  out  1  carry out of bit WIDTH-1

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, chunk counter=0, carry register=0.
- State machine:
  - IDLE: in_ready=1. When in_valid&&in_ready: register in1, in2 and cin, zero-padded to NCHUNK*CHUNK bits. Set counter=0, carry=cin. Go to RUN.
  - RUN: in_ready=0. Each cycle: chunk k = A[k] + B[k] + carry. Write the CHUNK-bit result into slice k of S. Carry register takes the chunk carry. Counter increments. After chunk NCHUNK-1, go to DONE.
  - DONE: out_valid=1. S and Cout stay stable until out_ready. On out_valid&&out_ready go to IDLE and drop out_valid.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. Minimum issue interval is NCHUNK+2 cycles.
- Partial top chunk (WIDTH mod CHUNK != 0): padded operand bits are 0. Cout = bit WIDTH of the padded sum, never the raw chunk carry. Upper padding bits of S are discarded.
- in_valid during RUN/DONE is ignored, and operands are not sampled.
- S may show partial results during RUN. Consumers must only use S when out_valid=1.
- CHUNK==WIDTH: single-cycle RUN, latency 1.
- Reset mid-RUN or mid-DONE aborts the operation. The pending result is lost. All outputs return to reset values asynchronously.
- Operand registers hold their value outside IDLE. In1/in2 may change freely after the accept edge.

Optional Feature:
- Macro: SEQ_ADDER_SUB_EN.
- With the macro: port sub exists, sampled at accept. sub=1 computes in1 + ~in2 + 1, and cin is ignored. Cout=1 means no borrow.
- Without the macro: no sub port; pure addition in1+in2+cin.

Decomposition:
- Package fp_arith_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - function nchunk(WIDTH, CHUNK)
  - the counter width, clog2(NCHUNK) with a minimum of 1
- One natural sub-module: chunk_adder, a CHUNK-bit combinational ripple of full-adder cells. Inputs a, b, cin; outputs sum and cout. Instantiated once and time-multiplexed across chunks.

Test Plan (WIDTH=25, CHUNK=8, NCHUNK=4 unless noted):
- in1=0x1FFFFFF, in2=0x0000001, cin=0 -> S=0x0000000, Cout=1; out_valid exactly 4 cycles after accept.
- in1=0x0123456, in2=0x0654321, cin=1 -> S=0x0777778, Cout=0; in_ready=0 from accept until the cycle after the output handshake.
- out_ready held 0 for 5 cycles in DONE, in_valid toggling with new operands -> S and Cout stable, out_valid=1 throughout, no new operand accepted; the result retires on the first out_ready=1.
- rst pulsed after the 2nd RUN cycle -> out_valid=0, S=0 and in_ready=1 immediately. The next op 0x0000010+0x0000020 yields S=0x0000030, Cout=0.
- Instances CHUNK=25 and CHUNK=1 with 0x1000000+0x1000000 -> S=0x0000000, Cout=1; latencies 1 and 25 cycles respectively.
- SEQ_ADDER_SUB_EN defined, sub=1, in1=5, in2=7 -> S=0x1FFFFFE, Cout=0; in1=7, in2=5 -> S=0x0000002, Cout=1.
